// File: rtl/wb_arb_pkg.sv
// Shared types for the two-master Wishbone arbiter: FSM states and one-hot
// grant encodings used by the top level and the debug grant port.
package wb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      G0    = 2'd1,
      G1    = 2'd2,
      ABORT = 2'd3
   } arb_state_t;

   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT_M0   = 2'b01;
   localparam logic [1:0] GNT_M1   = 2'b10;

endpackage

// File: rtl/wb_arb_wdog.sv
// Saturating ack watchdog: counts consecutive stalled strobe cycles and flags
// expiry on the stalled cycle that follows TIMEOUT_CYC-1 earlier ones.
module wb_arb_wdog #(
   parameter int TIMEOUT_CYC = 256,
   parameter int TW          = 9
) (
   input  logic clk_i,
   input  logic rst_n,
   input  logic enable,
   input  logic stall,
   input  logic clear,
   output logic expire
);

   localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [TW-1:0] CNT_SAT  = TW'(TIMEOUT_CYC);

   logic [TW-1:0] cnt_q;

   // NOTE: sequential state is written with non-blocking assignments only, so
   // every flop samples the pre-edge value of every other flop.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (!enable || clear) begin
         cnt_q <= '0;
      end else if (stall && cnt_q != CNT_SAT) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // A cycle carrying ack or err is never stalled, so ack wins on the threshold.
   assign expire = enable && stall && !clear && (cnt_q >= CNT_LAST);

endmodule

// File: rtl/wb_arb2.sv
// Two-master to one-slave Wishbone arbiter: round-robin grant held for the
// whole master cycle, with a watchdog that aborts stalled slave accesses.
module wb_arb2
   import wb_arb_pkg::*;
#(
   parameter int DW          = 32,
   parameter int AW          = 32,
   parameter int TIMEOUT_CYC = 256,
   parameter int TW          = 9
) (
   input  logic          clk_i,
   input  logic          rst_n,
   input  logic [DW-1:0] m0_wbd_dat_i,
   input  logic [AW-1:0] m0_wbd_adr_i,
   input  logic [3:0]    m0_wbd_sel_i,
   input  logic          m0_wbd_we_i,
   input  logic          m0_wbd_cyc_i,
   input  logic          m0_wbd_stb_i,
   output logic [DW-1:0] m0_wbd_dat_o,
   output logic          m0_wbd_ack_o,
   output logic          m0_wbd_err_o,
   input  logic [DW-1:0] m1_wbd_dat_i,
   input  logic [AW-1:0] m1_wbd_adr_i,
   input  logic [3:0]    m1_wbd_sel_i,
   input  logic          m1_wbd_we_i,
   input  logic          m1_wbd_cyc_i,
   input  logic          m1_wbd_stb_i,
   output logic [DW-1:0] m1_wbd_dat_o,
   output logic          m1_wbd_ack_o,
   output logic          m1_wbd_err_o,
   output logic [DW-1:0] s_wbd_dat_o,
   output logic [AW-1:0] s_wbd_adr_o,
   output logic [3:0]    s_wbd_sel_o,
   output logic          s_wbd_we_o,
   output logic          s_wbd_cyc_o,
   output logic          s_wbd_stb_o,
   input  logic [DW-1:0] s_wbd_dat_i,
   input  logic          s_wbd_ack_i,
   input  logic          s_wbd_err_i,
   output logic [1:0]    gnt_o
);

   arb_state_t state_q, state_d;
   logic       last_gnt_q;  // 0: m0 was granted last, 1: m1
   logic       err_pulse_q;
   logic       req0, req1, granted, own_cyc, own_stb, stall, expire;

   assign req0    = m0_wbd_cyc_i && m0_wbd_stb_i;
   assign req1    = m1_wbd_cyc_i && m1_wbd_stb_i;
   assign granted = (state_q == G0) || (state_q == G1);
   assign own_cyc = last_gnt_q ? m1_wbd_cyc_i : m0_wbd_cyc_i;
   assign own_stb = last_gnt_q ? m1_wbd_stb_i : m0_wbd_stb_i;
   assign stall   = granted && own_cyc && own_stb && !s_wbd_ack_i && !s_wbd_err_i;

   wb_arb_wdog #(
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .TW          (TW)
   ) u_wdog (
      .clk_i  (clk_i),
      .rst_n  (rst_n),
      .enable (granted),
      .stall  (stall),
      .clear  (!stall),
      .expire (expire)
   );

   // NOTE: every variable assigned in an always_comb gets a default first, so
   // no path through the block can leave it unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (req0 && (!req1 || last_gnt_q)) state_d = G0;
            else if (req1)                     state_d = G1;
         end
         G0: begin
            if (!m0_wbd_cyc_i) state_d = req1 ? G1 : IDLE;
            else if (expire)   state_d = ABORT;
         end
         G1: begin
            if (!m1_wbd_cyc_i) state_d = req0 ? G0 : IDLE;
            else if (expire)   state_d = ABORT;
         end
         ABORT: begin
            if (!own_cyc) begin
               if (last_gnt_q) state_d = req0 ? G0 : IDLE;
               else            state_d = req1 ? G1 : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         last_gnt_q  <= 1'b1;
         err_pulse_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         err_pulse_q <= (state_d == ABORT) && (state_q != ABORT);
         if (state_d == G0)      last_gnt_q <= 1'b0;
         else if (state_d == G1) last_gnt_q <= 1'b1;
      end
   end

   // Bus mux decodes only the registered state, so reset clears outputs at once.
   always_comb begin
      s_wbd_dat_o  = '0;
      s_wbd_adr_o  = '0;
      s_wbd_sel_o  = '0;
      s_wbd_we_o   = 1'b0;
      s_wbd_cyc_o  = 1'b0;
      s_wbd_stb_o  = 1'b0;
      m0_wbd_dat_o = '0;
      m0_wbd_ack_o = 1'b0;
      m0_wbd_err_o = 1'b0;
      m1_wbd_dat_o = '0;
      m1_wbd_ack_o = 1'b0;
      m1_wbd_err_o = 1'b0;
      gnt_o        = GNT_NONE;
      case (state_q)
         G0: begin
            s_wbd_dat_o  = m0_wbd_dat_i;
            s_wbd_adr_o  = m0_wbd_adr_i;
            s_wbd_sel_o  = m0_wbd_sel_i;
            s_wbd_we_o   = m0_wbd_we_i;
            s_wbd_cyc_o  = m0_wbd_cyc_i;
            s_wbd_stb_o  = m0_wbd_stb_i;
            m0_wbd_dat_o = s_wbd_dat_i;
            m0_wbd_ack_o = s_wbd_ack_i;
            m0_wbd_err_o = s_wbd_err_i;
            gnt_o        = GNT_M0;
         end
         G1: begin
            s_wbd_dat_o  = m1_wbd_dat_i;
            s_wbd_adr_o  = m1_wbd_adr_i;
            s_wbd_sel_o  = m1_wbd_sel_i;
            s_wbd_we_o   = m1_wbd_we_i;
            s_wbd_cyc_o  = m1_wbd_cyc_i;
            s_wbd_stb_o  = m1_wbd_stb_i;
            m1_wbd_dat_o = s_wbd_dat_i;
            m1_wbd_ack_o = s_wbd_ack_i;
            m1_wbd_err_o = s_wbd_err_i;
            gnt_o        = GNT_M1;
         end
         ABORT: begin
            if (last_gnt_q) begin
               m1_wbd_err_o = err_pulse_q;
               gnt_o        = GNT_M1;
            end else begin
               m0_wbd_err_o = err_pulse_q;
               gnt_o        = GNT_M0;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_wb_arb2.sv
// Self-checking bench for wb_arb2: directed scenarios plus randomized traffic,
// all compared against a cycle-level behavioural model of the arbiter rules.
module tb_wb_arb2;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int TIMEOUT_CYC = 8;
   localparam int TW = 4;

   logic clk_i = 1'b0;
   logic rst_n = 1'b0;
   logic [DW-1:0] m0_wbd_dat_i, m1_wbd_dat_i, s_wbd_dat_i;
   logic [AW-1:0] m0_wbd_adr_i, m1_wbd_adr_i;
   logic [3:0]    m0_wbd_sel_i, m1_wbd_sel_i;
   logic m0_wbd_we_i, m0_wbd_cyc_i, m0_wbd_stb_i;
   logic m1_wbd_we_i, m1_wbd_cyc_i, m1_wbd_stb_i;
   logic s_wbd_ack_i, s_wbd_err_i;
   logic [DW-1:0] m0_wbd_dat_o, m1_wbd_dat_o, s_wbd_dat_o;
   logic [AW-1:0] s_wbd_adr_o;
   logic [3:0]    s_wbd_sel_o;
   logic m0_wbd_ack_o, m0_wbd_err_o, m1_wbd_ack_o, m1_wbd_err_o;
   logic s_wbd_we_o, s_wbd_cyc_o, s_wbd_stb_o;
   logic [1:0] gnt_o;

   wb_arb2 #(.DW(DW), .AW(AW), .TIMEOUT_CYC(TIMEOUT_CYC), .TW(TW)) dut (
      .clk_i(clk_i), .rst_n(rst_n),
      .m0_wbd_dat_i(m0_wbd_dat_i), .m0_wbd_adr_i(m0_wbd_adr_i), .m0_wbd_sel_i(m0_wbd_sel_i),
      .m0_wbd_we_i(m0_wbd_we_i), .m0_wbd_cyc_i(m0_wbd_cyc_i), .m0_wbd_stb_i(m0_wbd_stb_i),
      .m0_wbd_dat_o(m0_wbd_dat_o), .m0_wbd_ack_o(m0_wbd_ack_o), .m0_wbd_err_o(m0_wbd_err_o),
      .m1_wbd_dat_i(m1_wbd_dat_i), .m1_wbd_adr_i(m1_wbd_adr_i), .m1_wbd_sel_i(m1_wbd_sel_i),
      .m1_wbd_we_i(m1_wbd_we_i), .m1_wbd_cyc_i(m1_wbd_cyc_i), .m1_wbd_stb_i(m1_wbd_stb_i),
      .m1_wbd_dat_o(m1_wbd_dat_o), .m1_wbd_ack_o(m1_wbd_ack_o), .m1_wbd_err_o(m1_wbd_err_o),
      .s_wbd_dat_o(s_wbd_dat_o), .s_wbd_adr_o(s_wbd_adr_o), .s_wbd_sel_o(s_wbd_sel_o),
      .s_wbd_we_o(s_wbd_we_o), .s_wbd_cyc_o(s_wbd_cyc_o), .s_wbd_stb_o(s_wbd_stb_o),
      .s_wbd_dat_i(s_wbd_dat_i), .s_wbd_ack_i(s_wbd_ack_i), .s_wbd_err_i(s_wbd_err_i),
      .gnt_o(gnt_o)
   );

   always #5 clk_i = ~clk_i;

   logic [140:0] obs;
   assign obs = {gnt_o, s_wbd_cyc_o, s_wbd_stb_o, s_wbd_we_o, s_wbd_sel_o, s_wbd_adr_o,
                 s_wbd_dat_o, m0_wbd_ack_o, m0_wbd_err_o, m0_wbd_dat_o,
                 m1_wbd_ack_o, m1_wbd_err_o, m1_wbd_dat_o};

   int n_run = 0;
   int n_fail = 0;

   // Reference model: owner of the bus (-1 none), last winner, stall run length.
   int own, last, stall_n;
   bit aborting, err_first;

   task automatic model_reset();
      own = -1; last = 1; stall_n = 0; aborting = 0; err_first = 0;
   endtask

   function automatic logic [140:0] model_exp();
      logic [1:0] g; logic sc, ss, sw, a0, e0, a1, e1;
      logic [3:0] sel; logic [31:0] adr, dat, d0, d1;
      g = 2'b00; sc = 0; ss = 0; sw = 0; sel = '0; adr = '0; dat = '0;
      a0 = 0; e0 = 0; d0 = '0; a1 = 0; e1 = 0; d1 = '0;
      if (own >= 0) begin
         g = (own == 0) ? 2'b01 : 2'b10;
         if (aborting) begin
            if (own == 0) e0 = err_first; else e1 = err_first;
         end else if (own == 0) begin
            sc = m0_wbd_cyc_i; ss = m0_wbd_stb_i; sw = m0_wbd_we_i; sel = m0_wbd_sel_i;
            adr = m0_wbd_adr_i; dat = m0_wbd_dat_i;
            d0 = s_wbd_dat_i; a0 = s_wbd_ack_i; e0 = s_wbd_err_i;
         end else begin
            sc = m1_wbd_cyc_i; ss = m1_wbd_stb_i; sw = m1_wbd_we_i; sel = m1_wbd_sel_i;
            adr = m1_wbd_adr_i; dat = m1_wbd_dat_i;
            d1 = s_wbd_dat_i; a1 = s_wbd_ack_i; e1 = s_wbd_err_i;
         end
      end
      return {g, sc, ss, sw, sel, adr, dat, a0, e0, d0, a1, e1, d1};
   endfunction

   task automatic model_update();
      bit r0, r1, stalled;
      int o;
      r0 = m0_wbd_cyc_i && m0_wbd_stb_i;
      r1 = m1_wbd_cyc_i && m1_wbd_stb_i;
      if (own < 0) begin
         if (r0 && (!r1 || last == 1)) begin own = 0; last = 0; end
         else if (r1) begin own = 1; last = 1; end
         stall_n = 0;
      end else if (!((own == 0) ? m0_wbd_cyc_i : m1_wbd_cyc_i)) begin
         o = 1 - own; aborting = 0; err_first = 0; stall_n = 0;
         if ((o == 0) ? r0 : r1) begin own = o; last = o; end
         else own = -1;
      end else if (aborting) begin
         err_first = 0;
      end else begin
         stalled = ((own == 0) ? m0_wbd_stb_i : m1_wbd_stb_i) && !s_wbd_ack_i && !s_wbd_err_i;
         if (!stalled) stall_n = 0;
         else if (stall_n == TIMEOUT_CYC - 1) begin
            aborting = 1; err_first = 1; stall_n = 0;
         end else stall_n++;
      end
   endtask

   // Advance one clock; leaves time at posedge+1 with the model updated.
   task automatic step();
      @(posedge clk_i);
      model_update();
      #1;
   endtask

   task automatic set_m0(input logic cyc, input logic stb, input logic [31:0] adr);
      m0_wbd_cyc_i = cyc; m0_wbd_stb_i = stb; m0_wbd_adr_i = adr;
      m0_wbd_we_i = 1'b0; m0_wbd_sel_i = 4'hf; m0_wbd_dat_i = 32'h0000_a000 | adr;
   endtask

   task automatic set_m1(input logic cyc, input logic stb, input logic [31:0] adr);
      m1_wbd_cyc_i = cyc; m1_wbd_stb_i = stb; m1_wbd_adr_i = adr;
      m1_wbd_we_i = 1'b1; m1_wbd_sel_i = 4'h3; m1_wbd_dat_i = 32'h0000_b000 | adr;
   endtask

   task automatic set_s(input logic ack, input logic err, input logic [31:0] dat);
      s_wbd_ack_i = ack; s_wbd_err_i = err; s_wbd_dat_i = dat;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      set_m0(0, 0, 0); set_m1(0, 0, 0); set_s(0, 0, 32'h1234_5678);
      model_reset();
      #7;
      @(negedge clk_i) rst_n = 1'b1;
      step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      set_m0(1, 1, 32'h40); set_m1(1, 1, 32'h80); set_s(1, 1, 32'hffff_ffff);
      model_reset();
      #3;
      n_run++;
      if (obs !== '0) begin
         n_fail++; $display("FAIL reset_outputs got %h exp 0", obs);
      end
      apply_reset();
      for (int i = 0; i < 2; i++) begin
         #1; n_run++;
         if (obs !== model_exp()) begin
            n_fail++; $display("FAIL reset_idle got %h exp %h", obs, model_exp());
         end
         step();
      end
   endtask

   task automatic test_single_read();
      set_m0(1, 1, 32'h100); set_s(0, 0, 32'h0);
      #1; n_run++;
      if (s_wbd_cyc_o !== 1'b0) begin
         n_fail++; $display("FAIL read_no_early_cyc got %b exp 0", s_wbd_cyc_o);
      end
      step();
      #1; n_run++;
      if (s_wbd_cyc_o !== 1'b1 || s_wbd_adr_o !== 32'h100) begin
         n_fail++; $display("FAIL read_cyc_latency got cyc=%b adr=%h exp cyc=1 adr=100", s_wbd_cyc_o, s_wbd_adr_o);
      end
      step();
      set_s(1, 0, 32'hDEAD_BEEF);
      #1; n_run++;
      if (m0_wbd_ack_o !== 1'b1 || m0_wbd_dat_o !== 32'hDEAD_BEEF || m1_wbd_ack_o !== 1'b0) begin
         n_fail++; $display("FAIL read_ack got ack0=%b dat0=%h ack1=%b exp 1 deadbeef 0",
                            m0_wbd_ack_o, m0_wbd_dat_o, m1_wbd_ack_o);
      end
      step();
      set_m0(0, 0, 0); set_s(0, 0, 0);
      for (int i = 0; i < 2; i++) begin
         #1; n_run++;
         if (obs !== model_exp()) begin
            n_fail++; $display("FAIL read_release got %h exp %h", obs, model_exp());
         end
         step();
      end
   endtask

   task automatic test_tie_rr();
      apply_reset();
      set_m0(1, 1, 32'h10); set_m1(1, 1, 32'h20);
      step();
      #1; n_run++;
      if (gnt_o !== 2'b01) begin
         n_fail++; $display("FAIL tie_first got %b exp 01", gnt_o);
      end
      step();
      set_m0(0, 0, 0);
      step();
      #1; n_run++;
      if (gnt_o !== 2'b10 || obs !== model_exp()) begin
         n_fail++; $display("FAIL tie_handoff got %b exp 10", gnt_o);
      end
      set_m1(0, 0, 0);
      step();
      #1; n_run++;
      if (gnt_o !== 2'b00) begin
         n_fail++; $display("FAIL tie_idle got %b exp 00", gnt_o);
      end
      set_m0(1, 1, 32'h30); set_m1(1, 1, 32'h40);
      step();
      #1; n_run++;
      if (gnt_o !== 2'b01) begin
         n_fail++; $display("FAIL tie_round_robin got %b exp 01", gnt_o);
      end
      set_m0(0, 0, 0); set_m1(0, 0, 0);
      step();
   endtask

   task automatic test_lock();
      set_m1(1, 1, 32'h200);
      step();
      set_m0(1, 1, 32'h300);
      for (int beat = 0; beat < 4; beat++) begin
         set_m1(1, 1, 32'h200 + 4 * beat); set_s(1, 0, 32'hC0DE_0000 + beat);
         #1; n_run++;
         if (gnt_o !== 2'b10 || obs !== model_exp()) begin
            n_fail++; $display("FAIL lock_beat%0d got %h exp %h", beat, obs, model_exp());
         end
         step();
         set_m1(1, 0, 32'h200); set_s(0, 0, 0);
         #1; n_run++;
         if (gnt_o !== 2'b10 || obs !== model_exp()) begin
            n_fail++; $display("FAIL lock_gap%0d got %h exp %h", beat, obs, model_exp());
         end
         step();
      end
      set_m1(0, 0, 0);
      step();
      #1; n_run++;
      if (gnt_o !== 2'b01) begin
         n_fail++; $display("FAIL lock_release got %b exp 01", gnt_o);
      end
      set_m0(0, 0, 0);
      step();
   endtask

   task automatic test_timeout();
      set_m1(1, 1, 32'h400); set_s(0, 0, 32'h5555_5555);
      step();
      for (int i = 0; i < TIMEOUT_CYC; i++) begin
         #1; n_run++;
         if (s_wbd_cyc_o !== 1'b1 || m1_wbd_err_o !== 1'b0) begin
            n_fail++; $display("FAIL timeout_stall%0d got cyc=%b err=%b exp 1 0", i, s_wbd_cyc_o, m1_wbd_err_o);
         end
         step();
      end
      #1; n_run++;
      if (s_wbd_cyc_o !== 1'b0 || s_wbd_stb_o !== 1'b0 || m1_wbd_err_o !== 1'b1) begin
         n_fail++; $display("FAIL timeout_abort got cyc=%b stb=%b err=%b exp 0 0 1",
                            s_wbd_cyc_o, s_wbd_stb_o, m1_wbd_err_o);
      end
      step();
      set_s(1, 0, 32'h5555_5555);
      #1; n_run++;
      if (m1_wbd_err_o !== 1'b0 || m1_wbd_ack_o !== 1'b0) begin
         n_fail++; $display("FAIL timeout_err_pulse got err=%b ack=%b exp 0 0", m1_wbd_err_o, m1_wbd_ack_o);
      end
      set_m1(0, 0, 0); set_s(0, 0, 0);
      step();
      #1; n_run++;
      if (gnt_o !== 2'b00) begin
         n_fail++; $display("FAIL timeout_idle got %b exp 00", gnt_o);
      end
   endtask

   task automatic test_ack_threshold();
      set_m1(1, 1, 32'h500); set_s(0, 0, 0);
      step();
      for (int i = 0; i < TIMEOUT_CYC - 1; i++) step();
      set_s(1, 0, 32'hA5A5_0008);
      #1; n_run++;
      if (m1_wbd_ack_o !== 1'b1 || m1_wbd_dat_o !== 32'hA5A5_0008 || m1_wbd_err_o !== 1'b0) begin
         n_fail++; $display("FAIL thresh_ack got ack=%b dat=%h err=%b exp 1 a5a50008 0",
                            m1_wbd_ack_o, m1_wbd_dat_o, m1_wbd_err_o);
      end
      step();
      set_m1(1, 0, 32'h500); set_s(0, 0, 0);
      #1; n_run++;
      if (gnt_o !== 2'b10 || s_wbd_cyc_o !== 1'b1 || m1_wbd_err_o !== 1'b0) begin
         n_fail++; $display("FAIL thresh_no_abort got gnt=%b cyc=%b err=%b exp 10 1 0",
                            gnt_o, s_wbd_cyc_o, m1_wbd_err_o);
      end
      set_m1(0, 0, 0);
      step();
   endtask

   task automatic test_reset_mid();
      set_m0(1, 1, 32'h600);
      step();
      #1; n_run++;
      if (s_wbd_cyc_o !== 1'b1) begin
         n_fail++; $display("FAIL rstmid_granted got %b exp 1", s_wbd_cyc_o);
      end
      rst_n = 1'b0;
      #1; n_run++;
      if (s_wbd_cyc_o !== 1'b0 || gnt_o !== 2'b00 || obs !== '0) begin
         n_fail++; $display("FAIL rstmid_async got cyc=%b gnt=%b exp 0 00", s_wbd_cyc_o, gnt_o);
      end
      model_reset();
      set_m0(0, 0, 0); set_m1(1, 1, 32'h700);
      #2 rst_n = 1'b1;
      step();
      #1; n_run++;
      if (gnt_o !== 2'b10 || obs !== model_exp()) begin
         n_fail++; $display("FAIL rstmid_regrant got %h exp %h", obs, model_exp());
      end
      set_m1(0, 0, 0);
      step();
   endtask

   task automatic test_random();
      int ack_pct;
      ack_pct = 30;
      for (int n = 0; n < 3000; n++) begin
         if (n % 250 == 0) ack_pct = (n / 250) % 3 == 0 ? 0 : ((n / 250) % 3 == 1 ? 25 : 60);
         if (m0_wbd_cyc_i) m0_wbd_cyc_i = ($urandom_range(99) >= 12);
         else              m0_wbd_cyc_i = ($urandom_range(99) < 30);
         if (m1_wbd_cyc_i) m1_wbd_cyc_i = ($urandom_range(99) >= 12);
         else              m1_wbd_cyc_i = ($urandom_range(99) < 30);
         m0_wbd_stb_i = m0_wbd_cyc_i && ($urandom_range(99) < 88);
         m1_wbd_stb_i = m1_wbd_cyc_i && ($urandom_range(99) < 88);
         m0_wbd_we_i = $urandom_range(1); m1_wbd_we_i = $urandom_range(1);
         m0_wbd_adr_i = $urandom; m1_wbd_adr_i = $urandom;
         m0_wbd_dat_i = $urandom; m1_wbd_dat_i = $urandom;
         m0_wbd_sel_i = 4'($urandom); m1_wbd_sel_i = 4'($urandom);
         s_wbd_ack_i = ($urandom_range(99) < ack_pct);
         s_wbd_err_i = ($urandom_range(99) < 3);
         s_wbd_dat_i = $urandom;
         #1; n_run++;
         if (obs !== model_exp()) begin
            n_fail++; $display("FAIL random_cyc%0d got %h exp %h", n, obs, model_exp());
         end
         step();
      end
      set_m0(0, 0, 0); set_m1(0, 0, 0); set_s(0, 0, 0);
      step(); step();
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_tie_rr();
      test_lock();
      test_timeout();
      test_ack_threshold();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule

// File: doc/wb_arb2.md
Name: wb_arb2

Overview:
- Two-master to one-slave Wishbone arbiter with round-robin grant and a per-transaction ack watchdog.
- Master 0 is the icache port; master 1 is the dcache port; the slave port drives the shared memory/peripheral bus.
- Grant is held for the whole master cycle (cyc high), so multi-beat accesses are not interleaved.
- A stalled slave is cut off after a programmable timeout, and the granted master receives err.

Parameters:
- DW, 32, data width
- AW, 32, address width
- TIMEOUT_CYC, 256, cycles with stb high and no ack before abort; must be ≥2
- TW, 9, timeout counter width; must satisfy 2^TW > TIMEOUT_CYC

Ports:
- clk_i  in  1  clock
- rst_n  in  1  asynchronous reset, active low
- mX_wbd_dat_i  in  DW  master X write data (X = 0, 1, for every mX line below)
- mX_wbd_adr_i  in  AW  master X address
- mX_wbd_sel_i  in  4  master X byte select
- mX_wbd_we_i  in  1  master X write enable
- mX_wbd_cyc_i  in  1  master X cycle
- mX_wbd_stb_i  in  1  master X strobe
- mX_wbd_dat_o  out  DW  read data to master X
- mX_wbd_ack_o  out  1  ack to master X
- mX_wbd_err_o  out  1  error (timeout) to master X
- s_wbd_dat_o  out  DW  write data to slave
- s_wbd_adr_o  out  AW  address to slave
- s_wbd_sel_o  out  4  byte select to slave
- s_wbd_we_o  out  1  write enable to slave
- s_wbd_cyc_o  out  1  cycle to slave
- s_wbd_stb_o  out  1  strobe to slave
- s_wbd_dat_i  in  DW  read data from slave
- s_wbd_ack_i  in  1  ack from slave
- s_wbd_err_i  in  1  error from slave
- gnt_o  out  2  one-hot current grant, for debug

Behaviour:
- Clocking and reset: one clock, clk_i. rst_n is asynchronous and active low.
- Reset state: IDLE; last_gnt = 1, so m0 wins the first tie; timeout counter = 0.
- Reset output values: gnt_o = 0; all s_* outputs = 0; all m*_ack_o, m*_err_o and m*_dat_o = 0.
- States: IDLE, G0, G1, ABORT.
- IDLE transitions: a request is mX cyc & stb.
  - Only one master requesting: go to its GX.
  - Both requesting: grant the master != last_gnt.
  - On entering GX, set last_gnt = X.
  - Latency is one cycle from request to s_wbd_cyc_o.
- GX (granted) muxing, combinational from the state register:
  - s_* follow master X.
  - mX_dat_o = s_wbd_dat_i.
  - mX_ack_o = s_wbd_ack_i.
  - mX_err_o = s_wbd_err_i.
  - The other master sees ack = err = 0 and dat = 0.
- GX release: at the edge where mX_wbd_cyc_i = 0:
  - If the other master is requesting, go directly to G(other) with no idle cycle.
  - Otherwise go to IDLE.
- Lock: while mX_wbd_cyc_i stays high, the grant is not revoked, even if stb drops between beats.
- Watchdog counting:
  - In GX, the counter increments on each cycle with stb high and ack = err = 0.
  - It clears on ack, on err, or on stb low.
  - When the counter = TIMEOUT_CYC-1 and another stalled cycle occurs, go to ABORT.
  - The counter saturates and never wraps.
- ABORT: s_wbd_cyc_o = s_wbd_stb_o = 0. mX_err_o = 1 for exactly one cycle (the first ABORT cycle) and then 0. Stay in ABORT until mX_wbd_cyc_i = 0, then apply the release rule above.
- Simultaneous events:
  - Slave ack arriving in the same cycle as the timeout threshold: the ack wins, the counter clears, and there is no abort.
  - Release in the same cycle as the other master's request: direct handoff.
- An s_wbd_ack_i arriving in IDLE or ABORT is ignored and not forwarded.
- Reset asserted mid-transaction: all outputs drop to 0 immediately (asynchronously) and the FSM returns to IDLE. The slave must tolerate cyc dropping mid-transfer.

Decomposition:
- Package wb_arb_pkg: state enum (IDLE, G0, G1, ABORT), one-hot grant constants GNT_NONE, GNT_M0, GNT_M1.
- Sub-module wb_arb_wdog:
  - Holds the saturating timeout counter.
  - Inputs: clk_i, rst_n, enable, stall, clear.
  - Output: expire.
  - Parameterised by TIMEOUT_CYC and TW.
- The top level holds the FSM and the mux.

Test Plan:
- Single m0 read: m0 cyc/stb, adr 0x100, slave acks the cycle after s cyc with dat 0xDEADBEEF → s_wbd_cyc_o rises 1 cycle after the request; m0_ack_o = 1 with m0_dat_o = 0xDEADBEEF; m1_ack_o stays 0.
- Tie after reset: m0 and m1 request in the same cycle → G0 first. m0 drops cyc with m1 still requesting → G1 on the next edge with no IDLE cycle. Both request again from IDLE → G0 (round-robin).
- Lock: m1 granted, performs 4 beats with stb low for 1 cycle between beats while cyc stays high; m0 requests throughout → gnt_o stays 2'b10 until m1 cyc drops.
- Timeout: TIMEOUT_CYC = 8, slave never acks a request from m1 → after 8 stalled cycles s_wbd_cyc_o = 0 and m1_err_o pulses for 1 cycle. m1 drops cyc → IDLE.
- Ack on the threshold cycle: slave acks on exactly the 8th stalled cycle → ack forwarded, no err, no ABORT.
- Reset mid-transaction: pull rst_n low during G0 between clock edges → s_wbd_cyc_o = 0 and gnt_o = 0 before the next edge. After release with only m1 requesting → G1 is granted.
